// File: rtl/dds_lut_loader.sv
// Streams a generated 4096-entry signed 8-bit waveform table into a DDS LUT config port.
// Optional checksum accumulator is enabled by defining DDS_LUT_LOADER_CKSUM_EN.
module dds_lut_loader #(
  parameter int unsigned CE_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  wave_sel,
  input  logic [8:0]  amplitude,
  output logic [7:0]  cfg,
  output logic        cfg_ce,
  output logic        cfg_reset,
  output logic        dds_hold,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam logic [7:0]  DivLast  = 8'(CE_DIV - 1);
  localparam logic [12:0] NumBytes = 13'd4096;

  typedef enum logic [2:0] {StIdle, StClr, StFill, StStream, StDone} state_e;

  state_e      state_q, state_d;
  logic [12:0] index_q, index_d;
  logic [7:0]  div_q, div_d;
  logic        fill_q, fill_d;
  logic [1:0]  wave_q, wave_d;
  logic [8:0]  amp_q, amp_d;
  logic [7:0]  cfg_q, cfg_d;
  logic        ce_q, ce_d;
  logic        clr_q, clr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        emit;
  logic        kill;

  // Sample generation for the current index from the latched waveform and gain.
  logic [10:0]        p;
  logic [21:0]        sq;
  logic [8:0]         m_full;
  logic [7:0]         m;
  logic [11:0]        tri_t;
  logic [7:0]         tri_v;
  logic [7:0]         raw;
  logic signed [16:0] prod;
  logic [7:0]         sample;

  always_comb begin
    p      = index_q[10:0];
    sq     = 22'(p) * (22'd2048 - 22'(p));
    m_full = 9'(sq >> 13);
    m      = (m_full > 9'd127) ? 8'd127 : m_full[7:0];
    tri_t  = index_q[11] ? (12'd4095 - index_q[11:0]) : index_q[11:0];
    tri_v  = 8'(tri_t >> 3);
    raw    = 8'd0;
    unique case (wave_q)
      2'd0: raw = index_q[11] ? (8'd0 - m) : m;
      2'd1: raw = tri_v - 8'd128;
      2'd2: raw = {~index_q[11], index_q[10:4]};
      2'd3: raw = index_q[11] ? 8'h81 : 8'h7f;
      default: raw = 8'd0;
    endcase
    prod   = $signed(raw) * $signed({8'd0, amp_q});
    sample = 8'(prod >>> 8);
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    div_d   = div_q;
    fill_d  = fill_q;
    wave_d  = wave_q;
    amp_d   = amp_q;
    cfg_d   = cfg_q;
    ce_d    = 1'b0;
    clr_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    emit    = 1'b0;
    kill    = abort && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
          wave_d  = wave_sel;
          amp_d   = (amplitude > 9'd256) ? 9'd256 : amplitude;
          index_d = '0;
        end
      end
      StClr: begin
        state_d = StFill;
        fill_d  = 1'b0;
      end
      StFill: begin
        fill_d = 1'b1;
        if (fill_q) begin
          emit    = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (ce_q && index_q == NumBytes) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (div_q == DivLast && !index_q[12]) begin
          emit = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (emit) begin
      ce_d    = 1'b1;
      cfg_d   = sample;
      index_d = index_q + 13'd1;
      div_d   = '0;
    end

    // Abort behaves like reset for the outputs; the partial table stays in the DDS.
    if (kill) begin
      state_d = StIdle;
      index_d = '0;
      div_d   = '0;
      fill_d  = 1'b0;
      cfg_d   = '0;
      ce_d    = 1'b0;
      clr_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      div_q   <= '0;
      fill_q  <= 1'b0;
      wave_q  <= '0;
      amp_q   <= '0;
      cfg_q   <= '0;
      ce_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      div_q   <= div_d;
      fill_q  <= fill_d;
      wave_q  <= wave_d;
      amp_q   <= amp_d;
      cfg_q   <= cfg_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DDS_LUT_LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (kill || (state_q == StIdle && start)) begin
      cksum_d = '0;
    end else if (emit) begin
      cksum_d = cksum_q + {8'd0, sample};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign cfg       = cfg_q;
  assign cfg_ce    = ce_q;
  assign cfg_reset = clr_q;
  assign dds_hold  = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dds_lut_loader.sv
// Randomized self-checking bench for dds_lut_loader against a arithmetic table model.
module tb_dds_lut_loader;

  logic clk = 1'b0;
  logic rst, start_v, abort_v, sel;
  logic [1:0] wave_sel;
  logic [8:0] amplitude;

  logic [7:0]  cfg1, cfg3;
  logic        ce1, ce3, clr1, clr3, hold1, hold3, busy1, busy3, done1, done3;
  logic [15:0] ck1, ck3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_lut_loader #(.CE_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(start_v & ~sel), .abort(abort_v & ~sel),
    .wave_sel(wave_sel), .amplitude(amplitude), .cfg(cfg1), .cfg_ce(ce1),
    .cfg_reset(clr1), .dds_hold(hold1), .busy(busy1), .done(done1), .checksum(ck1)
  );

  dds_lut_loader #(.CE_DIV(3)) u_dut3 (
    .clk(clk), .reset(rst), .start(start_v & sel), .abort(abort_v & sel),
    .wave_sel(wave_sel), .amplitude(amplitude), .cfg(cfg3), .cfg_ce(ce3),
    .cfg_reset(clr3), .dds_hold(hold3), .busy(busy3), .done(done3), .checksum(ck3)
  );

  logic [7:0]  m_cfg;
  logic        m_ce, m_clr, m_hold, m_busy, m_done;
  logic [15:0] m_ck;
  assign m_cfg  = sel ? cfg3 : cfg1;
  assign m_ce   = sel ? ce3 : ce1;
  assign m_clr  = sel ? clr3 : clr1;
  assign m_hold = sel ? hold3 : hold1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_ck   = sel ? ck3 : ck1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Table byte from the waveform definitions, using plain integer arithmetic.
  function automatic logic [7:0] ref_byte(input int wave, input int amp, input int i);
    int p, m, r, t, a, v;
    case (wave)
      0: begin
        p = i % 2048;
        m = (p * (2048 - p)) / 8192;
        if (m > 127) m = 127;
        r = (i >= 2048) ? -m : m;
      end
      1: begin
        t = (i >= 2048) ? 4095 - i : i;
        r = (t % 2048) / 8 - 128;
      end
      2: r = (i % 2048) / 16 - ((i < 2048) ? 128 : 0);
      default: r = (i >= 2048) ? -127 : 127;
    endcase
    a = (amp > 256) ? 256 : amp;
    v = (r * a) >>> 8;
    return v[7:0];
  endfunction

  // intr: 0 none, 1 abort, 2 reset -- applied right after strobe intr_idx.
  task automatic run_load(input int wave, input int amp, input int d, input int intr,
                          input int intr_idx, input bit mid_start, input bit start_at_done);
    int cyc, idx, sum, b, budget;
    bit fin;
    logic [15:0] ck_exp;
    wave_sel  = 2'(wave);
    amplitude = 9'(amp);
    start_v   = 1'b1;
    @(negedge clk);
    start_v   = 1'b0;
    cyc       = 1;
    wave_sel  = 2'($urandom);
    amplitude = 9'($urandom);
    check_eq("clr_pulse", 32'(m_clr), 32'd1);
    check_eq("busy_at_clr", 32'(m_busy), 32'd1);
    check_eq("hold_at_clr", 32'(m_hold), 32'd1);
    check_eq("ce_at_clr", 32'(m_ce), 32'd0);
    idx = 0; sum = 0; fin = 1'b0;
    budget = 5 + 4095 * d + 20;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start_v = 1'b0;
      check_eq("clr_once", 32'(m_clr), 32'd0);
      if (m_ce) begin
        b = int'(ref_byte(wave, amp, idx));
        check_eq("ce_cycle", 32'(cyc), 32'(4 + idx * d));
        check_eq($sformatf("byte[%0d]", idx), 32'(m_cfg), 32'(b));
        sum = (sum + b) % 65536;
        idx++;
        if (intr != 0 && idx == intr_idx + 1) begin
          if (intr == 1) abort_v = 1'b1;
          else rst = 1'b1;
          @(negedge clk);
          abort_v = 1'b0;
          rst     = 1'b0;
          check_eq("intr_busy", 32'(m_busy), 32'd0);
          check_eq("intr_hold", 32'(m_hold), 32'd0);
          check_eq("intr_ce", 32'(m_ce), 32'd0);
          check_eq("intr_done", 32'(m_done), 32'd0);
          check_eq("intr_cfg", 32'(m_cfg), 32'd0);
          check_eq("intr_clr", 32'(m_clr), 32'd0);
          check_eq("intr_ck", 32'(m_ck), 32'd0);
          repeat (2) begin
            @(negedge clk);
            check_eq("intr_no_done", 32'(m_done), 32'd0);
            check_eq("intr_idle", 32'(m_busy), 32'd0);
          end
          return;
        end
      end
      if (mid_start && cyc == 500) start_v = 1'b1;
      if (m_done) begin
        fin = 1'b1;
`ifdef DDS_LUT_LOADER_CKSUM_EN
        ck_exp = 16'(sum);
`else
        ck_exp = 16'd0;
`endif
        check_eq("done_cycle", 32'(cyc), 32'(5 + 4095 * d));
        check_eq("strobe_count", 32'(idx), 32'd4096);
        check_eq("busy_at_done", 32'(m_busy), 32'd0);
        check_eq("hold_at_done", 32'(m_hold), 32'd0);
        check_eq("checksum", 32'(m_ck), 32'(ck_exp));
        if (start_at_done) start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        check_eq("done_width", 32'(m_done), 32'd0);
        check_eq("idle_after_done", 32'(m_busy), 32'd0);
        check_eq("no_clr_after_done", 32'(m_clr), 32'd0);
        check_eq("checksum_hold", 32'(m_ck), 32'(ck_exp));
      end
    end
    check_eq("done_seen", 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start_v = 1'b0; abort_v = 1'b0; sel = 1'b0;
    wave_sel = 2'd0; amplitude = 9'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_cfg", 32'(m_cfg), 32'd0);
    check_eq("rst_ce", 32'(m_ce), 32'd0);
    check_eq("rst_clr", 32'(m_clr), 32'd0);
    check_eq("rst_hold", 32'(m_hold), 32'd0);
    check_eq("rst_busy", 32'(m_busy), 32'd0);
    check_eq("rst_done", 32'(m_done), 32'd0);
    check_eq("rst_ck", 32'(m_ck), 32'd0);
    check_eq("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_load(2, 256, 1, 0, 0, 1'b0, 1'b1);
    run_load(0, 256, 1, 0, 0, 1'b0, 1'b0);
    run_load(3, 128, 1, 0, 0, 1'b1, 1'b0);
    run_load(1, 300, 1, 0, 0, 1'b0, 1'b0);
    run_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)), 1, 0, 0, 1'b0, 1'b0);
    run_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)), 1, 0, 0, 1'b0, 1'b0);
    run_load(2, 200, 1, 1, 100, 1'b0, 1'b0);
    run_load(0, 256, 1, 0, 0, 1'b0, 1'b0);
    run_load(3, 77, 1, 2, 50, 1'b0, 1'b0);
    run_load(1, int'($urandom_range(0, 511)), 1, 0, 0, 1'b0, 1'b0);

    sel = 1'b1;
    @(negedge clk);
    run_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)), 3, 0, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
